// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, word/register types,
// operand-source and forwarding-select encodings.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_SRA  = 4'd2,
      ALU_ADD  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_NOR  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } aluop_t;

   typedef enum logic [1:0] {
      SRC_REG   = 2'd0,
      SRC_IMM   = 2'd1,
      SRC_SHIFT = 2'd2
   } alusrc_t;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwdsel_t;

   typedef struct packed {
      logic     valid;
      aluop_t   alu_op;
      alusrc_t  alusrc;
      word_t    rdat1;
      word_t    rdat2;
      word_t    imm;
      logic [4:0] shamt;
      regbits_t rs;
      regbits_t rt;
      regbits_t wsel;
      logic     regwr;
   } ex_lat_t;

   function automatic ex_lat_t bubble();
      ex_lat_t b;
      b        = '0;
      b.alu_op = ALU_SLL;
      b.alusrc = SRC_REG;
      return b;
   endfunction

endpackage

// File: rtl/ex_operand_latch_fwd_select.sv
// Per-source RAW bypass: picks EX/MEM, then MEM/WB,
// then the latched register-file word.
module fwd_select
   import cpu_types_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  regbits_t src_i,
   input  word_t    rdat_i,
   input  logic     exmem_regwr_i,
   input  regbits_t exmem_wsel_i,
   input  word_t    exmem_wdat_i,
   input  logic     memwb_regwr_i,
   input  regbits_t memwb_wsel_i,
   input  word_t    memwb_wdat_i,
   output word_t    fwd_o,
   output fwdsel_t  sel_o
);

   logic src_nz;
   logic hit_exmem;
   logic hit_memwb;

   assign src_nz    = (src_i != '0);
   assign hit_exmem = exmem_regwr_i &&
                      (exmem_wsel_i == src_i) && src_nz;
   assign hit_memwb = memwb_regwr_i &&
                      (memwb_wsel_i == src_i) && src_nz;

   always_comb begin
      sel_o = FWD_NONE;
      fwd_o = rdat_i;
      if (FWD_EN) begin
         if (hit_exmem) begin
            sel_o = FWD_EXMEM;
            fwd_o = exmem_wdat_i;
         end else if (hit_memwb) begin
            sel_o = FWD_MEMWB;
            fwd_o = memwb_wdat_i;
         end
      end
   end

endmodule

// File: rtl/ex_operand_latch.sv
// ID/EX pipeline register with stall/flush, operand
// forwarding and the ALU operand mux.
module ex_operand_latch
   import cpu_types_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       enable,
   input  logic       flush,
   input  logic       id_valid,
   input  aluop_t     id_alu_op,
   input  alusrc_t    id_alusrc,
   input  word_t      id_rdat1,
   input  word_t      id_rdat2,
   input  word_t      id_imm,
   input  logic [4:0] id_shamt,
   input  regbits_t   id_rs,
   input  regbits_t   id_rt,
   input  regbits_t   id_wsel,
   input  logic       id_regwr,
   input  logic       exmem_regwr,
   input  regbits_t   exmem_wsel,
   input  word_t      exmem_wdat,
   input  logic       memwb_regwr,
   input  regbits_t   memwb_wsel,
   input  word_t      memwb_wdat,
   output logic       ex_valid,
   output logic       ex_regwr,
   output regbits_t   ex_wsel,
   output aluop_t     alu_op,
   output word_t      port_a,
   output word_t      port_b,
   output word_t      ex_store_data,
   output fwdsel_t    fwd_a_sel,
   output fwdsel_t    fwd_b_sel
);

   ex_lat_t lat_q;
   ex_lat_t lat_d;
   word_t   fwd_rs;
   word_t   fwd_rt;

   always_comb begin
      lat_d = lat_q;
      if (flush) begin
         lat_d = bubble();
      end else if (enable) begin
         lat_d.valid  = id_valid;
         lat_d.alu_op = id_alu_op;
         lat_d.alusrc = id_alusrc;
         lat_d.rdat1  = id_rdat1;
         lat_d.rdat2  = id_rdat2;
         lat_d.imm    = id_imm;
         lat_d.shamt  = id_shamt;
         lat_d.rs     = id_rs;
         lat_d.rt     = id_rt;
         lat_d.wsel   = id_wsel;
         lat_d.regwr  = id_regwr & id_valid;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) lat_q <= bubble();
      else       lat_q <= lat_d;
   end

   fwd_select #(.FWD_EN(FWD_EN)) u_fwd_rs (
      .src_i         (lat_q.rs),
      .rdat_i        (lat_q.rdat1),
      .exmem_regwr_i (exmem_regwr),
      .exmem_wsel_i  (exmem_wsel),
      .exmem_wdat_i  (exmem_wdat),
      .memwb_regwr_i (memwb_regwr),
      .memwb_wsel_i  (memwb_wsel),
      .memwb_wdat_i  (memwb_wdat),
      .fwd_o         (fwd_rs),
      .sel_o         (fwd_a_sel)
   );

   fwd_select #(.FWD_EN(FWD_EN)) u_fwd_rt (
      .src_i         (lat_q.rt),
      .rdat_i        (lat_q.rdat2),
      .exmem_regwr_i (exmem_regwr),
      .exmem_wsel_i  (exmem_wsel),
      .exmem_wdat_i  (exmem_wdat),
      .memwb_regwr_i (memwb_regwr),
      .memwb_wsel_i  (memwb_wsel),
      .memwb_wdat_i  (memwb_wdat),
      .fwd_o         (fwd_rt),
      .sel_o         (fwd_b_sel)
   );

   // Reserved encoding 2'b11 falls into the register path.
   always_comb begin
      port_a = fwd_rs;
      port_b = fwd_rt;
      case (lat_q.alusrc)
         SRC_IMM: port_b = lat_q.imm;
         SRC_SHIFT: begin
            port_a = {27'b0, lat_q.shamt};
            port_b = fwd_rt;
         end
         default: ;
      endcase
   end

   assign ex_store_data = fwd_rt;
   assign ex_valid      = lat_q.valid;
   assign ex_regwr      = lat_q.regwr;
   assign ex_wsel       = lat_q.wsel;
   assign alu_op        = lat_q.alu_op;

endmodule

// File: tb/tb_ex_operand_latch.sv
// Directed vector table plus hand sequences for
// reset, stall, in-hold forwarding and flush.
module tb_ex_operand_latch;
   import cpu_types_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       enable, flush;
   logic       id_valid;
   aluop_t     id_alu_op;
   alusrc_t    id_alusrc;
   word_t      id_rdat1, id_rdat2, id_imm;
   logic [4:0] id_shamt;
   regbits_t   id_rs, id_rt, id_wsel;
   logic       id_regwr;
   logic       exmem_regwr, memwb_regwr;
   regbits_t   exmem_wsel, memwb_wsel;
   word_t      exmem_wdat, memwb_wdat;
   logic       ex_valid, ex_regwr;
   regbits_t   ex_wsel;
   aluop_t     alu_op;
   word_t      port_a, port_b, ex_store_data;
   fwdsel_t    fwd_a_sel, fwd_b_sel;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   ex_operand_latch dut (
      .CLK(CLK), .nRST(nRST),
      .enable(enable), .flush(flush),
      .id_valid(id_valid), .id_alu_op(id_alu_op),
      .id_alusrc(id_alusrc),
      .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
      .id_imm(id_imm), .id_shamt(id_shamt),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_wsel(id_wsel), .id_regwr(id_regwr),
      .exmem_regwr(exmem_regwr),
      .exmem_wsel(exmem_wsel),
      .exmem_wdat(exmem_wdat),
      .memwb_regwr(memwb_regwr),
      .memwb_wsel(memwb_wsel),
      .memwb_wdat(memwb_wdat),
      .ex_valid(ex_valid), .ex_regwr(ex_regwr),
      .ex_wsel(ex_wsel), .alu_op(alu_op),
      .port_a(port_a), .port_b(port_b),
      .ex_store_data(ex_store_data),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
   );

   typedef struct {
      aluop_t     op;
      logic [1:0] src;
      logic [4:0] rs, rt, ws;
      word_t      rd1, rd2, imm;
      logic [4:0] sh;
      logic       vld, rw;
      logic       xw;
      logic [4:0] xs;
      word_t      xd;
      logic       mw;
      logic [4:0] ms;
      word_t      md;
      word_t      ea, eb, es;
      logic       ev, er;
   } vec_t;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   task automatic idle_wb();
      exmem_regwr = 0; exmem_wsel = 0; exmem_wdat = 0;
      memwb_regwr = 0; memwb_wsel = 0; memwb_wdat = 0;
   endtask

   task automatic drive_id(input vec_t v);
      id_alu_op = v.op;
      id_alusrc = alusrc_t'(v.src);
      id_rs = v.rs; id_rt = v.rt; id_wsel = v.ws;
      id_rdat1 = v.rd1; id_rdat2 = v.rd2;
      id_imm = v.imm; id_shamt = v.sh;
      id_valid = v.vld; id_regwr = v.rw;
   endtask

   vec_t tbl[9];
   vec_t t;

   initial begin
      tbl[0] = '{ALU_ADD, 2'd0, 5'd1, 5'd2, 5'd3,
         32'd5, 32'd7, 32'd0, 5'd0, 1, 1,
         0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
         32'd5, 32'd7, 32'd7, 1, 1};
      tbl[1] = '{ALU_OR, 2'd1, 5'd1, 5'd2, 5'd4,
         32'h10, 32'h20, 32'h100, 5'd0, 1, 1,
         0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
         32'h10, 32'h100, 32'h20, 1, 1};
      tbl[2] = '{ALU_SUB, 2'd0, 5'd3, 5'd4, 5'd5,
         32'd1, 32'd9, 32'd0, 5'd0, 1, 1,
         1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB,
         32'hAA, 32'd9, 32'd9, 1, 1};
      tbl[3] = '{ALU_SUB, 2'd0, 5'd3, 5'd4, 5'd5,
         32'd1, 32'd9, 32'd0, 5'd0, 1, 0,
         0, 5'd3, 32'hAA, 1, 5'd4, 32'hBB,
         32'd1, 32'hBB, 32'hBB, 1, 0};
      tbl[4] = '{ALU_AND, 2'd0, 5'd5, 5'd0, 5'd6,
         32'h55, 32'd0, 32'd0, 5'd0, 1, 1,
         1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h1234,
         32'h55, 32'd0, 32'd0, 1, 1};
      tbl[5] = '{ALU_SLL, 2'd2, 5'd0, 5'd6, 5'd7,
         32'd0, 32'h99, 32'd0, 5'd4, 1, 1,
         0, 5'd0, 32'd0, 1, 5'd6, 32'h1,
         32'd4, 32'h1, 32'h1, 1, 1};
      tbl[6] = '{ALU_XOR, 2'd3, 5'd7, 5'd8, 5'd9,
         32'h70, 32'h80, 32'hDEAD, 5'd3, 1, 1,
         0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
         32'h70, 32'h80, 32'h80, 1, 1};
      tbl[7] = '{ALU_ADD, 2'd0, 5'd1, 5'd2, 5'd9,
         32'd3, 32'd4, 32'd0, 5'd0, 0, 1,
         0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
         32'd3, 32'd4, 32'd4, 0, 0};
      tbl[8] = '{ALU_SLT, 2'd0, 5'd10, 5'd11, 5'd12,
         32'd1, 32'd2, 32'd0, 5'd0, 1, 1,
         1, 5'd10, 32'hC0DE, 0, 5'd11, 32'hBAD,
         32'hC0DE, 32'd2, 32'd2, 1, 1};

      nRST = 0; enable = 0; flush = 0;
      t = tbl[0]; drive_id(t); idle_wb();
      #12;
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_op", 32'(alu_op), 32'(ALU_SLL));
      chk("rst_a", port_a, 0);
      chk("rst_b", port_b, 0);
      chk("rst_st", ex_store_data, 0);
      @(negedge CLK); nRST = 1;

      for (int i = 0; i < 9; i++) begin
         @(negedge CLK);
         t = tbl[i];
         drive_id(t); enable = 1; flush = 0;
         exmem_regwr = t.xw; exmem_wsel = t.xs;
         exmem_wdat = t.xd;
         memwb_regwr = t.mw; memwb_wsel = t.ms;
         memwb_wdat = t.md;
         @(posedge CLK); #1;
         chk($sformatf("v%0d_a", i), port_a, t.ea);
         chk($sformatf("v%0d_b", i), port_b, t.eb);
         chk($sformatf("v%0d_st", i), ex_store_data, t.es);
         chk($sformatf("v%0d_vld", i), 32'(ex_valid), 32'(t.ev));
         chk($sformatf("v%0d_rw", i), 32'(ex_regwr), 32'(t.er));
         chk($sformatf("v%0d_ws", i), 32'(ex_wsel), 32'(t.ws));
         chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(t.op));
      end

      // priority: drop exmem in place, memwb takes over
      @(negedge CLK);
      t = tbl[2]; drive_id(t);
      exmem_regwr = 1; exmem_wsel = 3; exmem_wdat = 32'hAA;
      memwb_regwr = 1; memwb_wsel = 3; memwb_wdat = 32'hBB;
      @(posedge CLK); #1;
      enable = 0;
      chk("pri_ex", port_a, 32'hAA);
      chk("pri_exsel", 32'(fwd_a_sel), 32'(FWD_EXMEM));
      exmem_regwr = 0; #1;
      chk("pri_mw", port_a, 32'hBB);
      chk("pri_mwsel", 32'(fwd_a_sel), 32'(FWD_MEMWB));

      // stall holds; forwarding still live in hold
      @(negedge CLK);
      idle_wb(); t = tbl[0]; drive_id(t); enable = 1;
      @(posedge CLK); #1;
      enable = 0;
      id_rdat1 = 32'h111; id_rdat2 = 32'h222;
      id_alu_op = ALU_NOR; id_wsel = 5'd20;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("hold_a", port_a, 32'd5);
      chk("hold_b", port_b, 32'd7);
      chk("hold_op", 32'(alu_op), 32'(ALU_ADD));
      chk("hold_ws", 32'(ex_wsel), 32'd3);
      exmem_regwr = 1; exmem_wsel = 1; exmem_wdat = 32'h77;
      #1;
      chk("hold_fwd", port_a, 32'h77);
      idle_wb(); #1;
      chk("hold_back", port_a, 32'd5);

      // async reset mid-cycle with nonzero state
      @(negedge CLK); #2;
      nRST = 0; #1;
      chk("arst_vld", 32'(ex_valid), 0);
      chk("arst_rw", 32'(ex_regwr), 0);
      chk("arst_ws", 32'(ex_wsel), 0);
      chk("arst_op", 32'(alu_op), 32'(ALU_SLL));
      chk("arst_a", port_a, 0);
      chk("arst_b", port_b, 0);
      @(negedge CLK); nRST = 1;

      // flush beats enable
      @(negedge CLK);
      t = tbl[1]; drive_id(t); enable = 1;
      @(posedge CLK); #1;
      t = tbl[0]; drive_id(t); flush = 1;
      @(posedge CLK); #1;
      flush = 0; enable = 0;
      chk("fl_vld", 32'(ex_valid), 0);
      chk("fl_rw", 32'(ex_regwr), 0);
      chk("fl_ws", 32'(ex_wsel), 0);
      chk("fl_op", 32'(alu_op), 32'(ALU_SLL));
      chk("fl_a", port_a, 0);
      chk("fl_b", port_b, 0);
      chk("fl_st", ex_store_data, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_operand_latch.md
# ex_operand_latch

Pipeline register and operand-forwarding stage between decode and the ALU. It captures decoded operands and control at each pipeline advance, then resolves RAW hazards combinationally against the EX/MEM and MEM/WB write-backs. It drives the ALU's `alu_op`, `port_a` and `port_b` directly, and supports stall (hold) and flush (bubble insertion).

## Interface
- `FWD_EN`, default 1: 1 enables forwarding. 0 makes operands come straight from the latched register-file data.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `enable` in 1: pipeline advance. 0 holds all latched state.
- `flush` in 1: load a bubble at the next edge. Takes priority over `enable`.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_alu_op` in `aluop_t`: ALU operation.
- `id_alusrc` in `alusrc_t` (2 bits), selects the operand source:
  - `SRC_REG`: port_b = rt.
  - `SRC_IMM`: port_b = imm.
  - `SRC_SHIFT`: port_a = shamt, port_b = rt.
- `id_rdat1`, `id_rdat2` in 32: register-file rs and rt data.
- `id_imm` in 32: already-extended immediate.
- `id_shamt` in 5: shift amount.
- `id_rs`, `id_rt`, `id_wsel` in 5: source and destination register numbers.
- `id_regwr` in 1: instruction writes `id_wsel`.
- `exmem_regwr` in 1, `exmem_wsel` in 5, `exmem_wdat` in 32: EX/MEM write-back.
- `memwb_regwr` in 1, `memwb_wsel` in 5, `memwb_wdat` in 32: MEM/WB write-back.
- `ex_valid` out 1, `ex_regwr` out 1, `ex_wsel` out 5: latched control.
- `alu_op` out `aluop_t`, `port_a` out 32, `port_b` out 32: ALU inputs.
- `ex_store_data` out 32: forwarded rt value, for stores.

## Operation
- **State.** Latched fields are valid, alu_op, alusrc, rdat1, rdat2, imm, shamt, rs, rt, wsel and regwr.
- **Register update** at each rising `CLK` edge, when `nRST` = 1:
  - `flush` = 1: load a bubble. valid = 0, regwr = 0, alu_op = `ALU_SLL`, all data and register fields = 0.
  - `flush` = 0, `enable` = 1: load all `id_*` inputs. Latched regwr = `id_regwr & id_valid`.
  - `flush` = 0, `enable` = 0: hold.
- **Forwarding**, evaluated per source `src` ∈ {rs, rt} on the latched register numbers, highest priority first:
  1. `exmem_regwr && exmem_wsel == src && src != 0`: use `exmem_wdat`.
  2. Else `memwb_regwr && memwb_wsel == src && src != 0`: use `memwb_wdat`.
  3. Else: use the latched rdat.
  - With `FWD_EN` = 0, always use the latched rdat.
- **Operand mux**:
  - `SRC_REG`: port_a = fwd_rs, port_b = fwd_rt.
  - `SRC_IMM`: port_a = fwd_rs, port_b = imm.
  - `SRC_SHIFT`: port_a = {27'b0, shamt}, port_b = fwd_rt. The ALU shifts port_b by port_a[4:0].
  - Reserved encoding 2'b11: treat as `SRC_REG`.
- **Store data.** `ex_store_data` = fwd_rt regardless of alusrc.
- **Register 0.** Register 0 is never forwarded, even when a write-back targets it with regwr = 1.
- **Invalid slot.** An invalid instruction (`id_valid` = 0) is latched normally but never asserts `ex_regwr`.

## Timing
- **Capture latency.** `id_*` → latched outputs takes 1 cycle.
- **Forwarding latency.** Write-back inputs → `port_a`/`port_b`/`ex_store_data` is combinational (0 cycles). The path must close within one cycle alongside the ALU.
- **Reset.** `nRST` = 0 asynchronously clears state to the bubble values. Resulting outputs:
  - `ex_valid` = 0, `ex_regwr` = 0, `ex_wsel` = 0.
  - `alu_op` = `ALU_SLL`, `port_a` = 0, `port_b` = 0.
  - `ex_store_data` = 0 (when `exmem_regwr`/`memwb_regwr` are 0).
- **Reset mid-stall.** Held state is lost. No recovery is required.
- **Flush + enable in the same cycle.** The bubble wins. The decode instruction is dropped; upstream re-issues it.
- **Stall.** Outputs stay stable except through forwarding. A write-back arriving during a hold updates operands in the same cycle.
- **Both write-backs hit the same register.** EX/MEM wins (youngest value).

## Structure
- **Package additions** (shared `cpu_types_pkg`):
  - `alusrc_t` enum {`SRC_REG`=0, `SRC_IMM`=1, `SRC_SHIFT`=2}.
  - `fwdsel_t` enum {`FWD_NONE`, `FWD_EXMEM`, `FWD_MEMWB`}.
  - Reused: `aluop_t`, `word_t`, `regbits_t`, `WORD_W`.
- **Sub-module** `fwd_select`: purely combinational. Takes one source register number, both write-back ports and the latched rdat. Returns the forwarded word plus a `fwdsel_t` for debug. Instantiated twice (rs, rt).
- **Top level** holds the latch `always_ff` and the operand mux.

## Test plan
- **Reset.** Drive `nRST` low mid-cycle with nonzero state → all outputs 0 and `alu_op` = `ALU_SLL` immediately, without waiting for a clock edge.
- **Plain capture and stall.** enable = 1, ADD, rdat1 = 5, rdat2 = 7, `SRC_REG` → next cycle port_a = 5, port_b = 7. Then enable = 0 with new `id_*` → values held.
- **Forward priority.** Latched rs = 3. `exmem_wsel` = 3 with wdat = 0xAA and `memwb_wsel` = 3 with wdat = 0xBB, both regwr = 1 → port_a = 0xAA. Drop `exmem_regwr` → port_a = 0xBB.
- **Register 0.** Latched rt = 0, `exmem_wsel` = 0, regwr = 1, wdat = 0xFFFF → port_b = latched rdat2 = 0.
- **Shift.** `SRC_SHIFT`, shamt = 4, rt forwarded from MEM/WB = 0x1 → port_a = 4, port_b = 1.
- **Flush wins.** flush = 1 and enable = 1 with `id_regwr` = 1, `id_valid` = 1 → next cycle `ex_valid` = 0, `ex_regwr` = 0, operands 0.
